// File: rtl/qmult_seq.sv
// Sequential sign-magnitude Q-format multiplier.
// The magnitudes are multiplied by shift-add, one partial product per cycle
// over N-1 cycles. A final NORM cycle then picks the Q-aligned window,
// optionally rounds it, and applies wrap or saturate on overflow. The sign is
// attached last, and a zero magnitude never carries a negative sign.
module qmult_seq #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_round,
  input  logic         i_sat,
  output logic         o_ready,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_ovr
);

  localparam int MW = N - 1;         // magnitude width
  localparam int PW = 2 * N - 2;     // full product width
  localparam int CW = $clog2(N);     // step counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q;            // running product
  logic [PW-1:0]   mcand_q;          // multiplicand, shifted left each step
  logic [MW-1:0]   mplier_q;         // multiplier, shifted right each step
  logic [CW-1:0]   cnt_q;
  logic            sign_q;
  logic            round_q;
  logic            sat_q;

  logic [MW-1:0]   m_trunc;
  logic            rnd_bit;
  logic [MW:0]     m_rnd;
  logic            hi_nz;
  logic            ovr;
  logic [MW-1:0]   mag;
  logic            sign_out;
  logic            unused_frac;

  // State register.
  // NOTE: state is updated with non-blocking assignments so that every flop
  // samples the values present before the edge, whatever the block order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, N-1 steps in CALC, one step in NORM.
  // NOTE: state_d gets its default before the case statement. Without that
  // default, a path that leaves it unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = CALC;
      CALC:    if (cnt_q == CW'(MW - 1)) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_ready = (state_q == IDLE);

  // Select the Q-aligned window of the product and apply half-up rounding.
  // Rounding uses the first bit below the window (bit Q-1), so it only exists
  // when Q > 0.
  assign m_trunc = acc_q[MW+Q-1:Q];
  generate
    if (Q > 0) begin : g_round
      assign rnd_bit = round_q & acc_q[Q-1];
    end else begin : g_no_round
      assign rnd_bit = 1'b0;
    end
  endgenerate
  assign m_rnd = {1'b0, m_trunc} + {{MW{1'b0}}, rnd_bit};

  // The product overflows if any bit above the window is set, or if rounding
  // carries out of the window.
  assign hi_nz = |acc_q[PW-1:MW+Q];
  assign ovr   = hi_nz | m_rnd[MW];

  // On overflow, saturate to full-scale magnitude or keep the low bits (wrap).
  // A zero magnitude is never given a negative sign.
  assign mag      = (ovr && sat_q) ? {MW{1'b1}} : m_rnd[MW-1:0];
  assign sign_out = sign_q & (|mag);

  // The fraction bits below the rounding bit do not affect the result.
  assign unused_frac = ^acc_q;

  // Datapath: capture operands on accept, shift-add in CALC, publish in NORM.
  // NOTE: every datapath flop, outputs included, sits on the asynchronous
  // reset. An abort therefore leaves no stale partial product behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      round_q  <= 1'b0;
      sat_q    <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_ovr    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            mcand_q  <= PW'(i_multiplicand[N-2:0]);
            mplier_q <= i_multiplier[N-2:0];
            sign_q   <= i_multiplicand[N-1] ^ i_multiplier[N-1];
            round_q  <= i_round;
            sat_q    <= i_sat;
          end
        end
        CALC: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        NORM: begin
          o_result <= {sign_out, mag};
          o_ovr    <= ovr;
          o_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qmult_seq.sv
// Self-checking bench for qmult_seq (N=32, Q=15).
// Stimulus issues operations and pushes the expected result, overflow flag
// and accept cycle onto a scoreboard. A monitor on the falling edge pops an
// entry on every o_done and compares it with the outputs.
module tb_qmult_seq;

  localparam int N = 32;
  localparam int Q = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a_in, b_in;
  logic         round_in, sat_in;
  logic         ready, done, ovr;
  logic [N-1:0] result;

  qmult_seq #(.Q(Q), .N(N)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_multiplicand (a_in),
    .i_multiplier   (b_in),
    .i_round        (round_in),
    .i_sat          (sat_in),
    .o_ready        (ready),
    .o_done         (done),
    .o_result       (result),
    .o_ovr          (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] res;
    logic         ovr;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  int           done_cyc[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           hold_viol = 0;
  logic [N-1:0] held_res = '0;
  logic         held_ovr = 1'b0;
  exp_t         mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the magnitudes.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic rnd, input logic sat);
    longint unsigned ma, mb, p, total, lim, m;
    exp_t e;
    ma    = 64'(a[N-2:0]);
    mb    = 64'(b[N-2:0]);
    p     = ma * mb;
    total = p >> Q;
    if (rnd && Q > 0) total = total + ((p >> (Q - 1)) & 64'd1);
    lim   = 64'd1 << (N - 1);
    e.ovr = (total >= lim);
    if (e.ovr) m = sat ? lim - 1 : total % lim;
    else       m = total;
    e.res = {(a[N-1] ^ b[N-1]) && (m != 0), m[N-2:0]};
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: score each o_done and check that the outputs hold between pulses.
  always @(negedge clk) begin
    if (rst) begin
      held_res = '0;
      held_ovr = 1'b0;
    end else if (done) begin
      done_cyc.push_back(cyc);
      check("done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("result",  64'(result), 64'(mon_e.res));
        check("ovr",     64'(ovr),    64'(mon_e.ovr));
        check("latency", 64'(cyc - mon_e.acc_cyc), 64'(N));
      end
      held_res = result;
      held_ovr = ovr;
    end else if (result !== held_res || ovr !== held_ovr) begin
      hold_viol++;
    end
  end

  // Step to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (ready) break;
      step();
    end
    check("ready_timeout", 64'(ready), 64'd1);
  endtask

  // Issue one operation. Optionally queue its expectation.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic rnd, input logic sat, input bit expect_it,
                       input logic [N-1:0] er, input logic eo);
    exp_t e;
    wait_ready();
    start    = 1'b1;
    a_in     = a;
    b_in     = b;
    round_in = rnd;
    sat_in   = sat;
    step();
    start = 1'b0;
    if (expect_it) begin
      e.res = er;
      e.ovr = eo;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic issue_model(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic rnd, input logic sat);
    exp_t e;
    e = model(a, b, rnd, sat);
    issue(a, b, rnd, sat, 1'b1, e.res, e.ovr);
  endtask

  initial begin
    int acc1;
    int n0;
    logic [N-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; round_in = 1'b0; sat_in = 1'b0;
    #1;
    check("rst_ready",  64'(ready),  64'd1);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovr",    64'(ovr),    64'd0);
    repeat (3) step();
    rst = 1'b0;

    // Directed cases: the first is accepted at the first edge after reset release.
    issue(32'h0000C000, 32'h00010000, 1'b0, 1'b0, 1'b1, 32'h00018000, 1'b0);
    issue(32'h8000C000, 32'h00010000, 1'b0, 1'b0, 1'b1, 32'h80018000, 1'b0);
    issue(32'h80000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0);
    issue(32'h00000001, 32'h00004000, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0);
    issue(32'h00000001, 32'h00004000, 1'b1, 1'b0, 1'b1, 32'h00000001, 1'b0);
    issue(32'h7FFFFFFF, 32'h00010000, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1);
    issue(32'h7FFFFFFF, 32'h00010000, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFE, 1'b1);

    // Abort: accept, pulse start mid-flight, then reset at cycle 10.
    wait_ready();
    check("pre_abort_result_nonzero", 64'(result != '0), 64'd1);
    issue(32'h00020000, 32'h00030000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (4) step();
    start = 1'b1; a_in = 32'h00011111; b_in = 32'h00022222;
    step();
    start = 1'b0;
    check("busy_ignores_start", 64'(ready), 64'd0);
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    check("abort_ready",  64'(ready),  64'd1);
    check("abort_done",   64'(done),   64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_ovr",    64'(ovr),    64'd0);
    repeat (2) step();
    rst = 1'b0;
    issue(32'h0000C000, 32'h00010000, 1'b0, 1'b0, 1'b1, 32'h00018000, 1'b0);

    // Back-to-back with start held high. Operands change during the first op.
    wait_ready();
    n0 = done_cyc.size();
    start = 1'b1; a_in = 32'h00008000; b_in = 32'h80030000; round_in = 1'b0; sat_in = 1'b0;
    step();
    acc1 = cyc;
    begin
      exp_t e;
      e = model(32'h00008000, 32'h80030000, 1'b0, 1'b0);
      e.acc_cyc = acc1;
      sb.push_back(e);
      a_in = 32'h0001C000; b_in = 32'h0000A000; round_in = 1'b1; sat_in = 1'b1;
      e = model(32'h0001C000, 32'h0000A000, 1'b1, 1'b1);
      e.acc_cyc = acc1 + N + 1;
      sb.push_back(e);
    end
    repeat (N + 1) step();
    start = 1'b0;
    check("b2b_second_accepted", 64'(ready), 64'd0);
    for (int i = 0; i < 100 && done_cyc.size() < n0 + 2; i++) step();
    check("b2b_two_dones", 64'(done_cyc.size() - n0), 64'd2);
    if (done_cyc.size() >= n0 + 2)
      check("b2b_spacing", 64'(done_cyc[n0+1] - done_cyc[n0]), 64'(N + 1));

    // Randomised operations, with scaled magnitudes to cover both ranges.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      ra[N-2:0] = ra[N-2:0] >> $urandom_range(0, 20);
      rb[N-2:0] = rb[N-2:0] >> $urandom_range(0, 20);
      if (k % 10 == 3) ra[N-2:0] = '0;
      issue_model(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step();
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) step();
    repeat (3) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("output_hold", 64'(hold_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
